// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, issues word requests to instruction memory
// and buffers returned instructions in an in-order queue for decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW+1:0] DEPTH_W = (CW + 2)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   q_data_q [DEPTH];
    logic [31:0]   q_pc_q   [DEPTH];
    logic [AW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] stale_q, stale_d;
    // Addresses of all outstanding requests, live or stale, in issue order
    logic [31:0]   f_pc_q [DEPTH];
    logic [AW-1:0] f_rd_q, f_rd_d, f_wr_q, f_wr_d;

    logic [CW+1:0] in_use;
    logic          issue, rsp_accept, rsp_live, rsp_stale, push, pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign in_use     = {2'b00, q_cnt_q} + {2'b00, live_q} + {2'b00, stale_q};
    assign imem_req   = rst_n && (in_use < DEPTH_W) && !redirect;
    assign imem_addr  = fetch_pc_q;
    assign issue      = imem_req && imem_gnt;
    // Responses with nothing outstanding are leftovers from before reset
    assign rsp_accept = imem_rvalid && ((live_q != '0) || (stale_q != '0));
    assign rsp_stale  = rsp_accept && (stale_q != '0);
    assign rsp_live   = rsp_accept && (stale_q == '0);
    assign push       = rsp_live && !redirect;
    assign inst_valid = (q_cnt_q != '0) && !redirect;
    assign pop        = inst_valid && inst_ready;
    assign inst_data  = q_data_q[q_rd_q];
    assign inst_pc    = q_pc_q[q_rd_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        q_rd_d     = q_rd_q;
        q_wr_d     = q_wr_q;
        q_cnt_d    = q_cnt_q;
        live_d     = live_q;
        stale_d    = stale_q;
        f_rd_d     = f_rd_q;
        f_wr_d     = f_wr_q;

        if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            f_wr_d     = ptr_inc(f_wr_q);
        end
        if (rsp_accept) begin
            f_rd_d = ptr_inc(f_rd_q);
        end

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            q_rd_d     = '0;
            q_wr_d     = '0;
            q_cnt_d    = '0;
            live_d     = '0;
            // Everything still in flight, minus a response landing now, must be dropped
            stale_d    = stale_q + live_q - CW'(rsp_accept);
        end else begin
            if (push) begin
                q_wr_d = ptr_inc(q_wr_q);
            end
            if (pop) begin
                q_rd_d = ptr_inc(q_rd_q);
            end
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
            live_d  = live_q + CW'(issue) - CW'(rsp_live);
            if (rsp_stale) begin
                stale_d = stale_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            q_rd_q     <= '0;
            q_wr_q     <= '0;
            q_cnt_q    <= '0;
            live_q     <= '0;
            stale_q    <= '0;
            f_rd_q     <= '0;
            f_wr_q     <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_data_q[i] <= '0;
                q_pc_q[i]   <= '0;
                f_pc_q[i]   <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            q_rd_q     <= q_rd_d;
            q_wr_q     <= q_wr_d;
            q_cnt_q    <= q_cnt_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
            f_rd_q     <= f_rd_d;
            f_wr_q     <= f_wr_d;
            if (issue) begin
                f_pc_q[f_wr_q] <= fetch_pc_q;
            end
            if (push) begin
                q_data_q[q_wr_q] <= imem_rdata;
                q_pc_q[q_wr_q]   <= f_pc_q[f_rd_q];
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order instruction memory model.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .DEPTH   (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } req_t;

    req_t        pending[$];
    int          total;
    int          bad;
    int          cyc;
    int          lat;
    logic        last_grant;
    logic [31:0] last_gaddr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0050_0093;
            32'h4:   return 32'h00a0_0113;
            32'h8:   return 32'h0020_81b3;
            default: return {16'hA5A5, a[15:0]};
        endcase
    endfunction

    // Advance one clock; inputs for the new cycle are valid 1 time unit after the edge,
    // outputs are sampled 2 time units after the edge.
    task automatic cycle();
        last_grant = imem_req && imem_gnt;
        last_gaddr = imem_addr;
        if (imem_rvalid && pending.size() > 0) void'(pending.pop_front());
        if (last_grant) pending.push_back('{due: cyc + lat, addr: imem_addr});
        @(posedge clk);
        #1;
        cyc++;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(pending[0].addr);
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        pending.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        redirect = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
        @(posedge clk);
        #2;
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %0h want 0", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", inst_valid); end
        total++; if (inst_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", inst_data); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", inst_pc); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
        #1;
        total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL post_rst_req: got %0h want 1", imem_req); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL post_rst_addr: got %h want 0", imem_addr); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc[3];
        logic [31:0] exp_dat[3];
        logic [31:0] pcs[$];
        logic [31:0] dat[$];
        int          pcyc[$];
        int          first_v;
        exp_pc  = '{32'h0, 32'h4, 32'h8};
        exp_dat = '{32'h0050_0093, 32'h00a0_0113, 32'h0020_81b3};
        do_reset();
        lat = 1; imem_gnt = 1'b1; inst_ready = 1'b1;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL stream_first_req: got %0h@%h want 1@0", imem_req, imem_addr); end
        first_v = -1;
        for (int i = 0; i < 20 && pcs.size() < 3; i++) begin
            if (inst_valid && first_v < 0) first_v = cyc;
            if (inst_valid && inst_ready) begin
                pcs.push_back(inst_pc);
                dat.push_back(inst_data);
                pcyc.push_back(cyc);
            end
            cycle();
        end
        total++; if (first_v !== 2) begin bad++; $display("FAIL stream_first_valid_cycle: got %0d want 2", first_v); end
        total++; if (pcs.size() !== 3) begin bad++; $display("FAIL stream_count: got %0d want 3", pcs.size()); end
        for (int i = 0; i < 3; i++) begin
            total++; if (pcs[i] !== exp_pc[i]) begin bad++; $display("FAIL stream_pc%0d: got %h want %h", i, pcs[i], exp_pc[i]); end
            total++; if (dat[i] !== exp_dat[i]) begin bad++; $display("FAIL stream_data%0d: got %h want %h", i, dat[i], exp_dat[i]); end
        end
        total++; if (pcyc[1] !== 3) begin bad++; $display("FAIL stream_second_cycle: got %0d want 3", pcyc[1]); end
    endtask

    task automatic test_backpressure();
        int          ng;
        int          first_ga_seen;
        logic [31:0] first_ga;
        logic [31:0] pcs[$];
        logic [31:0] dat[$];
        do_reset();
        lat = 1; imem_gnt = 1'b1; inst_ready = 1'b0;
        #1;
        ng = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (last_grant) ng++;
        end
        total++; if (ng !== 2) begin bad++; $display("FAIL bp_grants: got %0d want 2", ng); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL bp_req_full: got %0h want 0", imem_req); end
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr: got %h want 8", imem_addr); end
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin bad++; $display("FAIL bp_head: got %0h@%h want 1@0", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        #1;
        first_ga_seen = 0;
        first_ga = '0;
        for (int i = 0; i < 12 && (pcs.size() < 2 || first_ga_seen == 0); i++) begin
            if (inst_valid && inst_ready) begin
                pcs.push_back(inst_pc);
                dat.push_back(inst_data);
            end
            cycle();
            if (last_grant && first_ga_seen == 0) begin
                first_ga_seen = 1;
                first_ga = last_gaddr;
            end
        end
        total++; if (pcs[0] !== 32'h0) begin bad++; $display("FAIL bp_drain0: got %h want 0", pcs[0]); end
        total++; if (pcs[1] !== 32'h4 || dat[1] !== 32'h00a0_0113) begin bad++; $display("FAIL bp_drain1: got %h/%h want 4/00a00113", pcs[1], dat[1]); end
        total++; if (first_ga_seen !== 1 || first_ga !== 32'h8) begin bad++; $display("FAIL bp_resume: got %0d@%h want 1@8", first_ga_seen, first_ga); end
    endtask

    task automatic test_gnt_stall();
        int ng;
        int n4;
        do_reset();
        lat = 1; imem_gnt = 1'b1; inst_ready = 1'b1;
        #1;
        cycle();
        imem_gnt = 1'b0;
        #1;
        ng = 0;
        for (int k = 0; k < 3; k++) begin
            total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL stall_hold%0d: got %0h@%h want 1@4", k, imem_req, imem_addr); end
            cycle();
            if (last_grant) ng++;
        end
        total++; if (ng !== 0) begin bad++; $display("FAIL stall_grants: got %0d want 0", ng); end
        imem_gnt = 1'b1;
        #1;
        cycle();
        total++; if (last_grant !== 1'b1 || last_gaddr !== 32'h4) begin bad++; $display("FAIL stall_issue: got %0h@%h want 1@4", last_grant, last_gaddr); end
        imem_gnt = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL stall_advance: got %h want 8", imem_addr); end
        n4 = 0;
        for (int i = 0; i < 6; i++) begin
            if (inst_valid && inst_ready && inst_pc == 32'h4) begin
                n4++;
                total++; if (inst_data !== 32'h00a0_0113) begin bad++; $display("FAIL stall_data: got %h want 00a00113", inst_data); end
            end
            cycle();
        end
        total++; if (n4 !== 1) begin bad++; $display("FAIL stall_once: got %0d want 1", n4); end
    endtask

    task automatic test_redirect_inflight();
        int          seen;
        int          ga_seen;
        logic [31:0] ga;
        logic [31:0] ppc;
        logic [31:0] pdat;
        do_reset();
        lat = 3; imem_gnt = 1'b1; inst_ready = 1'b1;
        #1;
        cycle();
        cycle();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redir_two_inflight: got %0h want 0", imem_req); end
        redirect = 1'b1; redirect_pc = 32'h40;
        #1;
        cycle();
        redirect = 1'b0;
        #1;
        total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL redir_addr: got %h want 40", imem_addr); end
        seen = 0; ga_seen = 0; ga = '0; ppc = '0; pdat = '0;
        for (int i = 0; i < 20 && seen == 0; i++) begin
            if (inst_valid && inst_ready) begin
                seen = 1;
                ppc  = inst_pc;
                pdat = inst_data;
            end
            cycle();
            if (last_grant && ga_seen == 0) begin
                ga_seen = 1;
                ga = last_gaddr;
            end
        end
        total++; if (ga_seen !== 1 || ga !== 32'h40) begin bad++; $display("FAIL redir_first_req: got %0d@%h want 1@40", ga_seen, ga); end
        total++; if (seen !== 1 || ppc !== 32'h40) begin bad++; $display("FAIL redir_first_pc: got %0d@%h want 1@40", seen, ppc); end
        total++; if (pdat !== 32'hA5A5_0040) begin bad++; $display("FAIL redir_first_data: got %h want a5a50040", pdat); end
    endtask

    task automatic test_redirect_concurrent();
        int          seen;
        logic [31:0] ppc;
        do_reset();
        lat = 1; imem_gnt = 1'b1; inst_ready = 1'b1;
        #1;
        cycle();
        cycle();
        total++; if (inst_valid !== 1'b1 || imem_rvalid !== 1'b1) begin bad++; $display("FAIL redc_setup: got %0h/%0h want 1/1", inst_valid, imem_rvalid); end
        redirect = 1'b1; redirect_pc = 32'h43;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redc_valid_forced: got %0h want 0", inst_valid); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL redc_req_blocked: got %0h want 0", imem_req); end
        cycle();
        redirect = 1'b0;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL redc_next_req: got %0h@%h want 1@40", imem_req, imem_addr); end
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redc_flushed: got %0h want 0", inst_valid); end
        seen = 0; ppc = '0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (inst_valid && inst_ready) begin
                seen = 1;
                ppc  = inst_pc;
            end
            cycle();
        end
        total++; if (seen !== 1 || ppc !== 32'h40) begin bad++; $display("FAIL redc_first_pc: got %0d@%h want 1@40", seen, ppc); end
    endtask

    task automatic test_reset_midstream();
        int          seen;
        logic [31:0] ppc;
        logic [31:0] pdat;
        do_reset();
        lat = 1; imem_gnt = 1'b1; inst_ready = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) cycle();
        total++; if (inst_valid !== 1'b1 || imem_req !== 1'b0) begin bad++; $display("FAIL mid_full: got %0h/%0h want 1/0", inst_valid, imem_req); end
        #2;
        rst_n = 1'b0;
        pending.delete();
        imem_rvalid = 1'b0;
        #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid: got %0h want 0", inst_valid); end
        total++; if (inst_pc !== 32'h0 || inst_data !== 32'h0) begin bad++; $display("FAIL mid_async_head: got %h/%h want 0/0", inst_pc, inst_data); end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        imem_gnt = 1'b0; inst_ready = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin bad++; $display("FAIL mid_restart: got %0h@%h want 1@0", imem_req, imem_addr); end
        cycle();
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL mid_stray: got %0h want 0", inst_valid); end
        imem_gnt = 1'b1;
        #1;
        seen = 0; ppc = '0; pdat = '0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            if (inst_valid && inst_ready) begin
                seen = 1;
                ppc  = inst_pc;
                pdat = inst_data;
            end
            cycle();
        end
        total++; if (seen !== 1 || ppc !== 32'h0 || pdat !== 32'h0050_0093) begin bad++; $display("FAIL mid_first_inst: got %0d %h/%h want 1 0/00500093", seen, ppc, pdat); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        cyc   = 0;
        lat   = 1;
        last_grant = 1'b0;
        last_gaddr = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_gnt_stall();
        test_redirect_inflight();
        test_redirect_concurrent();
        test_reset_midstream();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
